// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared opcodes, state and mux encodings for the multi-cycle MIPS datapath
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Dispatch target out of DECODE; FETCH doubles as the illegal-opcode target.
  function automatic state_t decode_target(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE:     return S_EXEC;
      OP_LW, OP_SW: return S_MEMADR;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      OP_ADDI:      return S_ADDIEX;
      default:      return S_FETCH;
    endcase
  endfunction

  function automatic logic opcode_legal(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
           (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multi-cycle MIPS datapath with retired-instruction counter
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             Mem_Ready,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALU_op,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Illegal_Op,
  output logic [CNT_W-1:0] Instr_Count
);

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_zero_unused;

  // Zero is consumed by the datapath's PCWriteCond gate, not here.
  assign w_zero_unused = Zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = Mem_Ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = decode_target(Opcode);
      S_MEMADR: w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = Mem_Ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = Mem_Ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_B;
    ALU_op      = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    Illegal_Op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = ALUSRCB_FOUR;
        IRWrite  = Mem_Ready;
        PCWrite  = Mem_Ready;
      end
      S_DECODE: begin
        ALUSrcB    = ALUSRCB_IMM_SH;
        Illegal_Op = ~opcode_legal(Opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALU_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_op      = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEMWR: w_retire = Mem_Ready;
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign State       = r_state;
  assign Instr_Count = r_instr_count;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multi-cycle MIPS datapath: shared memory, IR, register file, ALU and PC muxes.
- Drives the 2-bit ALU_op consumed by the ALU control decoder (00 = add, 01 = subtract/compare, 10 = use funct field).
- Stalls on a memory-ready handshake and keeps a retired-instruction counter for performance and debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter Instr_Count.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- Opcode  input  6  IR[31:26], valid from DECODE onward
- Mem_Ready  input  1  memory completes the current read/write this cycle
- Zero  input  1  ALU zero flag (informational only; the datapath gates PCWriteCond with Zero)
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if Zero
- IorD  output  1  memory address select (0 = PC, 1 = ALUOut)
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write-data select (1 = MDR)
- RegDst  output  1  destination select (1 = rd, 0 = rt)
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALU_op  output  2  to ALU control decoder
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- State  output  4  current state (debug)
- Illegal_Op  output  1  one-cycle pulse for an unsupported opcode
- Instr_Count  output  CNT_W  instructions retired

Behaviour:
- Reset: one clock with reset = 1 sets State = FETCH (0) and Instr_Count = 0. Reset is synchronous and overrides any in-progress instruction, including a pending memory wait.
- Outputs are combinational from State, plus Mem_Ready where stated. Every output not listed for a state is 0. Immediately after reset the outputs are the FETCH values.
- State encoding and per-state outputs:
  - FETCH (0): MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALU_op = 00, PCSource = 00, IRWrite = PCWrite = Mem_Ready. Stay in FETCH while Mem_Ready = 0; go to DECODE when it is 1.
  - DECODE (1): ALUSrcA = 0, ALUSrcB = 11, ALU_op = 00.
  - MEMADR (2) and ADDIEX (10): ALUSrcA = 1, ALUSrcB = 10, ALU_op = 00.
  - MEMRD (3): MemRead = 1, IorD = 1. Wait for Mem_Ready.
  - MEMWB (4): RegDst = 0, MemtoReg = 1, RegWrite = 1.
  - MEMWR (5): MemWrite = 1, IorD = 1. Wait for Mem_Ready.
  - EXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALU_op = 10.
  - ALUWB (7): RegDst = 1, MemtoReg = 0, RegWrite = 1.
  - BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALU_op = 01, PCWriteCond = 1, PCSource = 01.
  - JUMP (9): PCWrite = 1, PCSource = 10.
  - ADDIWB (11): RegDst = 0, MemtoReg = 0, RegWrite = 1.
- Transitions out of DECODE, by Opcode:
  - 000000 (R-type) -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> FETCH, with Illegal_Op = 1 during the DECODE cycle
- Other transitions:
  - MEMADR -> MEMRD if the opcode is lw, else MEMWR.
  - MEMRD -> MEMWB when Mem_Ready = 1.
  - MEMWR -> FETCH when Mem_Ready = 1.
  - EXEC -> ALUWB; ADDIEX -> ADDIWB.
  - ALUWB, ADDIWB, MEMWB, BRANCH, JUMP -> FETCH.
  - Unused encodings 12-15 -> FETCH, with all outputs 0.
- Latency with no wait states: lw 5 cycles; sw, R-type, addi 4; beq, j 3. Each memory wait cycle adds 1.
- Instr_Count increments by 1 on the clock edge leaving a final state: MEMWB, MEMWR (only when Mem_Ready = 1), ALUWB, ADDIWB, BRANCH, JUMP.
  - An illegal opcode does not increment the counter.
  - The counter wraps modulo 2^CNT_W.
  - Reset takes priority over an increment in the same cycle.
- Mem_Ready is ignored in states that are not memory states.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - the 4-bit state encodings
  - ALU_op encodings (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10)
  - ALUSrcB and PCSource select encodings
- The same constants are reused by the ALU control decoder and the datapath.
- Single module, no sub-module. The ALU control decoder stays a separate instance in the datapath.

Test Plan:
- Hold reset 2 cycles with Mem_Ready = 1, then release -> State = 0, Instr_Count = 0, MemRead = 1, IRWrite = 1, PCWrite = 1.
- R-type (Opcode = 000000), Mem_Ready = 1 -> states 0,1,6,7,0; ALU_op = 10 in EXEC; RegWrite = 1 and RegDst = 1 in ALUWB; Instr_Count = 1.
- lw (100011) with Mem_Ready = 0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; IorD = 1 in MEMRD; MemtoReg = 1 in MEMWB; 7 cycles total.
- beq (000100) then j (000010) -> BRANCH has ALU_op = 01, PCWriteCond = 1, PCSource = 01; JUMP has PCWrite = 1, PCSource = 10; Instr_Count advances by 2.
- Illegal Opcode = 111111 -> Illegal_Op = 1 for exactly 1 cycle in DECODE, next state FETCH, Instr_Count unchanged.
- Assert reset during the MEMWR wait -> State = 0 on the next edge, MemWrite = 0, Instr_Count = 0. Separately, preload Instr_Count = 2^32 - 1 and retire one instruction -> Instr_Count = 0.
